// File: rtl/window_feed_controller.sv
// Streams one image frame from a 1-cycle-latency RAM into a shifting window
// buffer through a 2-entry FIFO, tagging pixels that complete a KERNEL x KERNEL window.
module window_feed_controller #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int KERNEL      = 9,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [PIXEL_WIDTH-1:0] rd_data,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   shift_en,
  input  logic                   shift_ready,
  output logic                   window_valid,
  output logic [ADDR_WIDTH-1:0]  win_row,
  output logic [ADDR_WIDTH-1:0]  win_col,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMG_W - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] K_OFF     = ADDR_WIDTH'(KERNEL - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [1:0]             count_q, count_d;
  logic                   inflight_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [PIXEL_WIDTH-1:0] fifo_q [2];
  logic                   push, pop, issue_req, in_window;
  logic [2:0]             pending;

  assign push     = inflight_q;
  assign shift_en = (count_q != 2'd0);
  assign pop      = shift_en & shift_ready;
  // The slot freed by this cycle's pop is credited so a read can refill it at once.
  assign pending   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue_req = (state_q == FETCH) || ((state_q == IDLE) && start);
  assign rd_en     = issue_req && (pending < 3'd2);
  assign rd_addr   = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      DRAIN:   if (pending == 3'd0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: ;
    endcase
    if (rd_en) begin
      if (addr_q == LAST_ADDR) begin
        state_d = DRAIN;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + ADDR_ONE;
      end
    end
  end

  // Row/column of the FIFO head pixel; they advance only when that pixel is taken.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q == IDLE) begin
      row_d = '0;
      col_d = '0;
    end else if (pop) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ADDR_ONE;
      end else begin
        col_d = col_q + ADDR_ONE;
      end
    end
  end

  assign pixel_out    = fifo_q[rd_ptr_q];
  assign in_window    = (row_q >= K_OFF) && (col_q >= K_OFF);
  assign window_valid = shift_en && in_window;
  assign win_row      = window_valid ? row_q - K_OFF : '0;
  assign win_col      = window_valid ? col_q - K_OFF : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      // NOTE: only two slots, so they are cleared to give pixel_out a defined 0 in reset.
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
      if (push) begin
        fifo_q[wr_ptr_q] <= rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_window_feed_controller.sv
// Self-checking bench for window_feed_controller: a RAM model feeds the DUT and a
// raster-order scoreboard derives every expected pixel, window flag and coordinate.
module tb_window_feed_controller;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int KERNEL = 9;
  localparam int PW     = 8;
  localparam int AW     = 10;
  localparam int NPIX   = IMG_W * IMG_H;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          shift_ready = 1'b1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data = '0;
  logic [PW-1:0] pixel_out;
  logic          shift_en;
  logic          window_valid;
  logic [AW-1:0] win_row, win_col;
  logic          busy, done;

  window_feed_controller #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_out(pixel_out), .shift_en(shift_en), .shift_ready(shift_ready),
    .window_valid(window_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [PW-1:0] ram [NPIX];
  always @(posedge clock) if (rd_en) rd_data <= ram[rd_addr];

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Observation record, sampled mid-cycle on the falling edge.
  logic [PW-1:0] xp[$];
  bit            xwv[$];
  logic [AW-1:0] xr[$], xc[$];
  int            xcyc[$];
  int            issued, max_out, first_se, done_cnt, done_cyc, stall_viol, start_cyc;
  bit            prev_stall, prev_done, rand_ready;
  logic          busy_after_done;
  logic [PW-1:0] p_pix;
  logic          p_wv;
  logic [AW-1:0] p_r, p_c;

  int n_checks = 0;
  int n_pass   = 0;

  always @(negedge clock) begin
    if (rd_en) issued++;
    if (shift_en && shift_ready) begin
      xp.push_back(pixel_out);
      xwv.push_back(window_valid);
      xr.push_back(win_row);
      xc.push_back(win_col);
      xcyc.push_back(cyc);
    end
    if (shift_en && first_se < 0) first_se = cyc;
    if (issued - xp.size() > max_out) max_out = issued - xp.size();
    if (prev_stall && (!shift_en || pixel_out !== p_pix || window_valid !== p_wv ||
                       win_row !== p_r || win_col !== p_c)) stall_viol++;
    prev_stall = shift_en && !shift_ready;
    p_pix = pixel_out; p_wv = window_valid; p_r = win_row; p_c = win_col;
    if (prev_done) busy_after_done = busy;
    prev_done = done;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_rec();
    xp.delete(); xwv.delete(); xr.delete(); xc.delete(); xcyc.delete();
    issued = 0; max_out = 0; first_se = -1; done_cnt = 0; done_cyc = -1;
    stall_viol = 0; prev_stall = 0; prev_done = 0; busy_after_done = 1'bx;
  endtask

  task automatic fill_ram(input bit random_data);
    for (int i = 0; i < NPIX; i++) ram[i] = random_data ? PW'($urandom) : PW'(i % 256);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) begin
      @(posedge clock); #1;
      if (rand_ready) shift_ready = 1'($urandom_range(0, 1));
    end
    shift_ready = 1'b1;
    if (done_cnt == 0) begin
      n_checks++;
      $display("FAIL done_timeout: no done after %0d cycles", limit);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_xfer(input int n, input int limit);
    for (int i = 0; i < limit && xp.size() < n; i++) begin
      @(posedge clock); #1;
    end
    if (xp.size() < n) begin
      n_checks++;
      $display("FAIL xfer_timeout: %0d transfers, wanted %0d", xp.size(), n);
    end
  endtask

  // Scoreboard: pixel j is RAM[j] at raster position (j / IMG_W, j % IMG_W).
  function automatic int stream_errors(output int first_bad);
    int errs = 0;
    first_bad = -1;
    for (int j = 0; j < NPIX && j < xp.size(); j++) begin
      int r, c, er, ec;
      bit ewv;
      r   = j / IMG_W;
      c   = j % IMG_W;
      ewv = (r >= KERNEL - 1) && (c >= KERNEL - 1);
      er  = ewv ? r - (KERNEL - 1) : 0;
      ec  = ewv ? c - (KERNEL - 1) : 0;
      if (xp[j] !== ram[j] || xwv[j] !== ewv || xr[j] !== AW'(er) || xc[j] !== AW'(ec)) begin
        errs++;
        if (first_bad < 0) first_bad = j;
      end
    end
    return errs;
  endfunction

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({rd_en, shift_en, window_valid, busy, done} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {rd_en, shift_en, window_valid, busy, done});
    else n_pass++;
    n_checks++;
    if ({rd_addr, pixel_out, win_row, win_col} !== '0)
      $display("FAIL reset_buses: rd_addr=%0d pixel=%0d row=%0d col=%0d expected all 0",
               rd_addr, pixel_out, win_row, win_col);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, rd_en, shift_en} !== 3'b0)
      $display("FAIL idle_after_reset: busy/rd_en/shift_en=%b expected 000", {busy, rd_en, shift_en});
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int errs, bad, wcnt, wfirst, wlast, last_cyc;
    fill_ram(1'b0);
    clear_rec();
    pulse_start();
    wait_done(4 * NPIX);
    n_checks++;
    if (first_se !== start_cyc + 2)
      $display("FAIL first_latency: shift_en at cycle %0d expected %0d", first_se, start_cyc + 2);
    else n_pass++;
    errs = stream_errors(bad);
    n_checks++;
    if (xp.size() != NPIX || errs != 0)
      $display("FAIL full_stream: got %0d pixels %0d bad (first %0d) expected %0d clean", xp.size(), errs, bad, NPIX);
    else n_pass++;
    last_cyc = (xcyc.size() > 0) ? xcyc[xcyc.size() - 1] : -1;
    n_checks++;
    if (xcyc.size() == 0 || last_cyc - xcyc[0] != NPIX - 1)
      $display("FAIL full_throughput: span %0d cycles expected %0d", last_cyc - ((xcyc.size() > 0) ? xcyc[0] : 0), NPIX - 1);
    else n_pass++;
    wcnt = 0; wfirst = -1; wlast = -1;
    for (int j = 0; j < xwv.size(); j++) if (xwv[j]) begin
      wcnt++;
      if (wfirst < 0) wfirst = j;
      wlast = j;
    end
    n_checks++;
    if (wcnt != 400) $display("FAIL window_count: got %0d expected 400", wcnt);
    else n_pass++;
    n_checks++;
    if (wfirst != 232 || xr[232] !== AW'(0) || xc[232] !== AW'(0))
      $display("FAIL first_window: index %0d expected 232 with row/col 0", wfirst);
    else n_pass++;
    n_checks++;
    if (wlast != 783 || xr[783] !== AW'(19) || xc[783] !== AW'(19))
      $display("FAIL last_window: index %0d expected 783 with row/col 19", wlast);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL full_done_count: got %0d expected 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (done_cyc != last_cyc + 1)
      $display("FAIL done_timing: done at %0d expected %0d", done_cyc, last_cyc + 1);
    else n_pass++;
    n_checks++;
    if (busy_after_done !== 1'b0)
      $display("FAIL busy_after_done: got %b expected 0", busy_after_done);
    else n_pass++;
  endtask

  task automatic test_stall();
    int errs, bad, held, last_cyc;
    fill_ram(1'b0);
    clear_rec();
    pulse_start();
    wait_xfer(50, 200);
    shift_ready = 1'b0;
    held = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (shift_en === 1'b1 && pixel_out === PW'(50)) held++;
      @(posedge clock); #1;
    end
    shift_ready = 1'b1;
    wait_done(4 * NPIX);
    n_checks++;
    if (held != 5) $display("FAIL stall_hold: pixel 50 held %0d of 5 cycles", held);
    else n_pass++;
    n_checks++;
    if (stall_viol != 0) $display("FAIL stall_stable: %0d outputs changed while stalled, expected 0", stall_viol);
    else n_pass++;
    n_checks++;
    if (max_out > 2) $display("FAIL stall_outstanding: got %0d expected at most 2", max_out);
    else n_pass++;
    errs = stream_errors(bad);
    n_checks++;
    if (xp.size() != NPIX || errs != 0)
      $display("FAIL stall_stream: got %0d pixels %0d bad (first %0d) expected %0d clean", xp.size(), errs, bad, NPIX);
    else n_pass++;
    n_checks++;
    if (xcyc.size() < 52 || xcyc[50] - xcyc[49] != 6 || xcyc[51] - xcyc[50] != 1)
      $display("FAIL stall_resume: gaps around pixel 50 wrong, expected 6 then 1 cycles");
    else n_pass++;
    last_cyc = (xcyc.size() > 0) ? xcyc[xcyc.size() - 1] : -1;
    n_checks++;
    if (xcyc.size() == 0 || last_cyc - xcyc[0] != NPIX - 1 + 5)
      $display("FAIL stall_span: last transfer at %0d, span expected %0d", last_cyc, NPIX + 4);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    int errs, bad, wcnt;
    fill_ram(1'b1);
    clear_rec();
    pulse_start();
    rand_ready = 1'b1;
    wait_done(20 * NPIX);
    rand_ready = 1'b0;
    errs = stream_errors(bad);
    n_checks++;
    if (xp.size() != NPIX || errs != 0)
      $display("FAIL random_stream: got %0d pixels %0d bad (first %0d) expected %0d clean", xp.size(), errs, bad, NPIX);
    else n_pass++;
    n_checks++;
    if (max_out > 2) $display("FAIL random_overrun: outstanding %0d expected at most 2", max_out);
    else n_pass++;
    n_checks++;
    if (stall_viol != 0) $display("FAIL random_stall_stable: %0d changes expected 0", stall_viol);
    else n_pass++;
    wcnt = 0;
    foreach (xwv[j]) if (xwv[j]) wcnt++;
    n_checks++;
    if (wcnt != 400) $display("FAIL random_windows: got %0d expected 400", wcnt);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL random_done: got %0d expected 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_restart();
    int errs, bad;
    fill_ram(1'b0);
    clear_rec();
    pulse_start();
    wait_xfer(300, 600);
    pulse_start();
    wait_done(4 * NPIX);
    errs = stream_errors(bad);
    n_checks++;
    if (xp.size() != NPIX || errs != 0 || done_cnt != 1)
      $display("FAIL restart_ignored: got %0d pixels %0d bad, %0d done, expected %0d clean and 1 done",
               xp.size(), errs, done_cnt, NPIX);
    else n_pass++;
    clear_rec();
    pulse_start();
    wait_done(4 * NPIX);
    errs = stream_errors(bad);
    n_checks++;
    if (xp.size() != NPIX || errs != 0 || done_cnt != 1)
      $display("FAIL second_frame: got %0d pixels %0d bad (first %0d), %0d done, expected %0d clean and 1 done",
               xp.size(), errs, bad, done_cnt, NPIX);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int errs, bad;
    fill_ram(1'b0);
    clear_rec();
    pulse_start();
    wait_xfer(100, 300);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({rd_en, shift_en, window_valid, busy, done} !== 5'b0)
      $display("FAIL midreset_flags: got %b expected 00000", {rd_en, shift_en, window_valid, busy, done});
    else n_pass++;
    n_checks++;
    if ({rd_addr, pixel_out, win_row, win_col} !== '0)
      $display("FAIL midreset_buses: rd_addr=%0d pixel=%0d row=%0d col=%0d expected all 0",
               rd_addr, pixel_out, win_row, win_col);
    else n_pass++;
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_checks++;
    if (done_cnt != 0 || xp.size() != 100 || busy !== 1'b0)
      $display("FAIL midreset_abandon: done=%0d transfers=%0d busy=%b expected 0, 100, 0",
               done_cnt, xp.size(), busy);
    else n_pass++;
    clear_rec();
    pulse_start();
    wait_done(4 * NPIX);
    n_checks++;
    if (xp.size() == 0 || xp[0] !== ram[0])
      $display("FAIL midreset_first_pixel: got %0d expected %0d", (xp.size() > 0) ? xp[0] : 'x, ram[0]);
    else n_pass++;
    errs = stream_errors(bad);
    n_checks++;
    if (xp.size() != NPIX || errs != 0)
      $display("FAIL midreset_stream: got %0d pixels %0d bad (first %0d) expected %0d clean", xp.size(), errs, bad, NPIX);
    else n_pass++;
  endtask

  initial begin
    rand_ready = 1'b0;
    clear_rec();
    test_reset();
    test_full_frame();
    test_stall();
    test_random_ready();
    test_restart();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
